alu_uart_host: RTL and testbench
================================

Name: alu_uart_host

Overview:
Initiator end of the UART ALU link; it drives the same byte protocol that the board-side ALU interface answers. On a start request it writes operand A, operand B and the opcode as three bytes into a UART TX FIFO. It then waits for the single result byte from the UART RX path, with a timeout. It sits in a host/loopback test harness between user logic and a uart_tx/fifo/uart_rx stack.

Parameters:
NB_DATA, 8, operand/result/byte width
NB_CODE, 6, opcode width; the opcode byte is zero-extended to NB_DATA
NB_TIMEOUT, 16, width of the response timeout counter
TIMEOUT_CYCLES, 50000, clock cycles to wait in WAIT before declaring a timeout (must be >=1 and <2^NB_TIMEOUT)

Ports:
i_clk  in  1  system clock; all logic is on the rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  request a transaction; sampled only in IDLE
i_op_a  in  NB_DATA  operand A; latched on an accepted start
i_op_b  in  NB_DATA  operand B; latched on an accepted start
i_code  in  NB_CODE  ALU opcode; latched on an accepted start
o_busy  out  1  high whenever the state is not IDLE
o_tx_data  out  NB_DATA  byte presented to the TX FIFO write port
o_tx_wr  out  1  TX FIFO write strobe
i_tx_full  in  1  TX FIFO full
i_rx_done  in  1  one-cycle pulse from uart_rx: a byte is valid
i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
o_result  out  NB_DATA  last result byte received
o_result_valid  out  1  one-cycle pulse: o_result has been updated
o_timeout  out  1  one-cycle pulse: no response arrived within TIMEOUT_CYCLES

Behaviour:
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT. State encoding is free.
- Reset (i_reset=0, asynchronous): state=IDLE, latched operands=0, timeout counter=0, o_result=0, o_result_valid=0, o_timeout=0.
- IDLE: if i_start=1, latch A, B and {0,code} at the clock edge and go to SEND_A. Otherwise remain in IDLE.
- SEND_A, SEND_B, SEND_OP: o_tx_data is combinational from state and the latched value (A, B, {0,code} respectively). o_tx_wr = ~i_tx_full.
  - If i_tx_full=0: advance one state per cycle (SEND_A->SEND_B->SEND_OP->WAIT).
  - If i_tx_full=1: hold the state, keep o_tx_wr=0. No byte is dropped or duplicated.
- Outside the SEND states: o_tx_wr=0 and o_tx_data=0.
- With no backpressure, the bytes are written on cycles 1, 2 and 3 after the start edge, in the order A, B, opcode.
- WAIT: the timeout counter is cleared on entry and increments each cycle that i_rx_done=0.
  - i_rx_done=1: o_result<=i_rx_data, o_result_valid=1 for the next cycle, state becomes IDLE.
  - Counter==TIMEOUT_CYCLES-1 with i_rx_done=0: o_timeout=1 for the next cycle, state becomes IDLE, o_result unchanged.
  - i_rx_done and the timeout condition in the same cycle: the result wins and o_timeout stays 0.
- o_result_valid and o_timeout are registered single-cycle pulses. They are never high together.
- i_rx_done outside WAIT is ignored: stray or late bytes have no effect on outputs.
- i_start outside IDLE is ignored. A start in the cycle that o_result_valid or o_timeout is high is accepted, because the state is already IDLE.
- Operand inputs may change freely after the start is accepted; only the latched copies are transmitted.
- Reset asserted mid-transaction aborts immediately: no further o_tx_wr and no completion pulse. A partial frame may remain in the FIFO; flushing it is system-level.
- Counter arithmetic is unsigned NB_TIMEOUT-bit. The counter never wraps because it is cleared on WAIT entry.

Test Plan:
- Basic ADD: A=0x05, B=0x03, code=6'h20 with start pulse, i_tx_full=0 -> o_tx_wr high on 3 consecutive cycles with data 0x05, 0x03, 0x20. Drive rx byte 0x08 -> o_result=0x08, single-cycle o_result_valid, o_busy drops.
- Backpressure: i_tx_full=1 for 4 cycles while in SEND_B (A=0xF0, B=0x0F, code=6'h24) -> no write during the stall. Exactly one write of 0x0F after full drops, then 0x24. Write count totals 3.
- Timeout: TIMEOUT_CYCLES=20, no rx -> o_timeout pulses exactly 20 cycles after entering WAIT. o_result keeps its previous value and o_result_valid stays 0.
- Simultaneous events: rx_done with 0x7E on the final timeout cycle -> o_result_valid=1, o_result=0x7E, o_timeout=0.
- Ignored inputs: i_rx_done with 0xAA in IDLE -> o_result and the pulses are unchanged. i_start with new operands during WAIT -> no extra TX writes.
- Reset mid-operation: assert i_reset=0 in SEND_B -> o_busy=0 and all outputs 0 asynchronously. After release, a new transaction (0x02, 0x02, 6'h20 -> reply 0x04) completes normally.

Source files
------------

// File: rtl/alu_uart_host.sv
// alu_uart_host: initiator side of the UART ALU link.
// A start request latches A, B and the opcode. The block then pushes them as
// three bytes into the UART TX FIFO, honouring the FIFO's full flag. After
// that it waits, with a timeout, for the single result byte from the RX path.
module alu_uart_host #(
    parameter int NB_DATA        = 8,
    parameter int NB_CODE        = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_op_a,
    input  logic [NB_DATA-1:0] i_op_b,
    input  logic [NB_CODE-1:0] i_code,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_wr,
    input  logic               i_tx_full,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic               o_timeout
);

    // Last counter value before the response is declared missing.
    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_SEND_OP,
        ST_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [NB_DATA-1:0]    op_a_q;
    logic [NB_DATA-1:0]    op_b_q;
    logic [NB_DATA-1:0]    code_q;
    logic [NB_TIMEOUT-1:0] wait_cnt;
    logic                  accept_start;
    logic                  enter_wait;
    logic                  timeout_hit;

    // The opcode travels as a full byte with zeros in the unused upper bits.
    function automatic logic [NB_DATA-1:0] zext_code(input logic [NB_CODE-1:0] c);
        return NB_DATA'(c);
    endfunction

    assign accept_start = (state == ST_IDLE) && i_start;
    assign enter_wait   = (state == ST_SEND_OP) && !i_tx_full;
    assign timeout_hit  = (state == ST_WAIT) && !i_rx_done && (wait_cnt == TIMEOUT_LAST);
    assign o_busy       = (state != ST_IDLE);

    // State register; reset aborts any frame in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and TX write port; a full FIFO stalls the current byte.
    always_comb begin
        state_next = state;
        o_tx_wr    = 1'b0;
        o_tx_data  = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                o_tx_data = op_a_q;
                o_tx_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    state_next = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                o_tx_data = op_b_q;
                o_tx_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    state_next = ST_SEND_OP;
                end
            end
            ST_SEND_OP: begin
                o_tx_data = code_q;
                o_tx_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A received byte and an expiring timer both end the wait.
                if (i_rx_done || (wait_cnt == TIMEOUT_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture on an accepted start; later input changes are ignored.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_a_q <= '0;
            op_b_q <= '0;
            code_q <= '0;
        end else if (accept_start) begin
            op_a_q <= i_op_a;
            op_b_q <= i_op_b;
            code_q <= zext_code(i_code);
        end
    end

    // Response timer: cleared on the way into WAIT so it never wraps.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wait_cnt <= '0;
        end else if (enter_wait) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !i_rx_done) begin
            wait_cnt <= wait_cnt + NB_TIMEOUT'(1);
        end
    end

    // Completion pulses; a byte arriving on the last cycle beats the timeout.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            if ((state == ST_WAIT) && i_rx_done) begin
                o_result       <= i_rx_data;
                o_result_valid <= 1'b1;
            end else if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host with a transaction-level model: expected
// TX bytes and expected completion events are queued by the stimulus and
// consumed by a compare process on every falling edge.
module tb_alu_uart_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [5:0] code;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] result;
    logic       result_valid;
    logic       timeout;

    typedef struct {
        bit         is_to;
        logic [7:0] data;
    } ev_t;

    int         checks      = 0;
    int         failures    = 0;
    int         tx_wr_count = 0;
    int         w0;
    logic [7:0] exp_tx[$];
    ev_t        exp_ev[$];
    ev_t        cmp_ev;
    logic [7:0] cmp_byte;
    logic [7:0] model_result = 8'h00;

    alu_uart_host #(
        .NB_DATA(8), .NB_CODE(6), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(20)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start),
        .i_op_a(op_a), .i_op_b(op_b), .i_code(code),
        .o_busy(busy), .o_tx_data(tx_data), .o_tx_wr(tx_wr), .i_tx_full(tx_full),
        .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_result(result), .o_result_valid(result_valid), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive a start for one edge and record the frame it must produce.
    task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] c);
        op_a  = a;
        op_b  = b;
        code  = c;
        start = 1'b1;
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back({2'b00, c});
        tick();
        start = 1'b0;
    endtask

    task automatic expect_event(input bit is_to, input logic [7:0] d);
        ev_t e;
        e.is_to = is_to;
        e.data  = d;
        exp_ev.push_back(e);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) tick();
        chk("idle_reached", busy, 0);
    endtask

    // Transaction-level compare: every write must be the next expected byte,
    // every pulse the next expected event, and o_result the last good reply.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_wr) begin
                tx_wr_count++;
                chk("wr_while_full", tx_full, 0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx_write: got %0h expected no write", tx_data);
                end else begin
                    cmp_byte = exp_tx.pop_front();
                    chk("tx_byte", tx_data, cmp_byte);
                end
            end
            if (!busy) chk("tx_data_idle", tx_data, 0);
            chk("pulse_exclusive", result_valid & timeout, 0);
            if (result_valid || timeout) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got valid=%0b timeout=%0b expected none",
                             result_valid, timeout);
                end else begin
                    cmp_ev = exp_ev.pop_front();
                    chk("event_kind", timeout, cmp_ev.is_to);
                    if (!cmp_ev.is_to) model_result = cmp_ev.data;
                end
            end
            chk("result_value", result, model_result);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op_a    = 8'h00;
        op_b    = 8'h00;
        code    = 6'h00;
        tx_full = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tick_n(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_tx_wr", tx_wr, 0);
        tick();

        // Basic ADD: three back-to-back writes, then the reply.
        expect_event(1'b0, 8'h08);
        start_txn(8'h05, 8'h03, 6'h20);
        @(negedge clk);
        chk("add_wr1", tx_wr, 1);
        chk("add_byte_a", tx_data, 8'h05);
        chk("add_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("add_byte_b", tx_data, 8'h03);
        tick();
        @(negedge clk);
        chk("add_byte_op", tx_data, 8'h20);
        tick();
        rx_data = 8'h08;
        rx_done = 1'b1;
        @(negedge clk);
        chk("add_wait_no_wr", tx_wr, 0);
        chk("add_wait_busy", busy, 1);
        tick();
        rx_done = 1'b0;
        @(negedge clk);
        chk("add_valid", result_valid, 1);
        chk("add_result", result, 8'h08);
        chk("add_not_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("add_valid_single", result_valid, 0);
        tick();

        // Backpressure while SEND_B is presenting its byte.
        w0 = tx_wr_count;
        expect_event(1'b0, 8'hFF);
        start_txn(8'hF0, 8'h0F, 6'h24);
        @(negedge clk);
        chk("bp_byte_a", tx_data, 8'hF0);
        tick();
        tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_stall_no_wr", tx_wr, 0);
            tick();
        end
        tx_full = 1'b0;
        @(negedge clk);
        chk("bp_wr_after_full", tx_wr, 1);
        chk("bp_byte_b", tx_data, 8'h0F);
        tick();
        @(negedge clk);
        chk("bp_byte_op", tx_data, 8'h24);
        tick();
        chk("bp_write_count", tx_wr_count - w0, 3);
        rx_pulse(8'hFF);
        wait_idle(10);
        tick();

        // Timeout: pulse exactly 20 cycles after entering WAIT.
        expect_event(1'b1, 8'h00);
        start_txn(8'h01, 8'h01, 6'h20);
        tick_n(3);
        for (int k = 1; k <= 20; k++) begin
            tick();
            @(negedge clk);
            if (k < 20) chk("to_early", timeout, 0);
        end
        chk("to_pulse", timeout, 1);
        chk("to_no_valid", result_valid, 0);
        chk("to_result_kept", result, 8'hFF);
        chk("to_not_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("to_single", timeout, 0);
        tick();

        // Reply on the final timeout cycle: the result wins.
        expect_event(1'b0, 8'h7E);
        start_txn(8'h02, 8'h03, 6'h21);
        tick_n(3);
        tick_n(19);
        rx_pulse(8'h7E);
        @(negedge clk);
        chk("sim_valid", result_valid, 1);
        chk("sim_result", result, 8'h7E);
        chk("sim_no_timeout", timeout, 0);
        tick();
        @(negedge clk);
        chk("sim_timeout_after", timeout, 0);
        tick();

        // Stray byte in IDLE is ignored.
        rx_pulse(8'hAA);
        @(negedge clk);
        chk("stray_result", result, 8'h7E);
        chk("stray_valid", result_valid, 0);
        chk("stray_busy", busy, 0);
        tick();

        // Start requests during WAIT produce no writes.
        expect_event(1'b0, 8'h30);
        start_txn(8'h10, 8'h20, 6'h21);
        tick_n(3);
        w0    = tx_wr_count;
        op_a  = 8'h99;
        op_b  = 8'h98;
        code  = 6'h3F;
        start = 1'b1;
        tick_n(5);
        start = 1'b0;
        chk("wait_start_no_tx", tx_wr_count - w0, 0);
        chk("wait_still_busy", busy, 1);
        rx_data = 8'h30;
        rx_done = 1'b1;
        tick();
        // Start offered in the cycle the valid pulse is high.
        rx_done = 1'b0;
        op_a    = 8'h11;
        op_b    = 8'h22;
        code    = 6'h01;
        start   = 1'b1;
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h01);
        @(negedge clk);
        chk("ign_valid", result_valid, 1);
        chk("ign_result", result, 8'h30);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("b2b_wr", tx_wr, 1);
        chk("b2b_byte_a", tx_data, 8'h11);
        tick();

        // Reset in SEND_B aborts at once.
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tx_wr", tx_wr, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_result", result, 0);
        chk("arst_valid", result_valid, 0);
        chk("arst_timeout", timeout, 0);
        exp_tx.delete();
        model_result = 8'h00;
        tick_n(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        tick();

        expect_event(1'b0, 8'h04);
        start_txn(8'h02, 8'h02, 6'h20);
        @(negedge clk);
        chk("post_byte_a", tx_data, 8'h02);
        tick_n(3);
        rx_pulse(8'h04);
        @(negedge clk);
        chk("post_valid", result_valid, 1);
        chk("post_result", result, 8'h04);
        wait_idle(10);
        tick_n(2);

        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("event_queue_drained", exp_ev.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
